// File: rtl/data_mem_responder.sv
// Data-memory responder: services RV32I loads/stores against an internal word RAM.
// Latency: LATENCY edges from accept to access edge; ready pulses the cycle after; faults complete at once.
// Backpressure: one request in flight; requests seen in WAIT/DONE are ignored, busy stalls the requester.
//
// Ports: clk/rst (sync, active-high); MemRead/MemWrite request strobes; funct3 size/sign;
//        addr byte address; wdata store data; rdata load result; ready completion pulse;
//        fault rejected-access flag (valid with ready); busy request in flight.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        fault,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [2:0]              funct3_q;
    logic [31:0]             wdata_q;
    logic                    store_q;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    fault_q;
    logic                    busy_q;
    logic [31:0]             mem_q [2**ADDR_WIDTH];

    // Upper address bits alias; they are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

    logic                  req_illegal;
    logic                  access;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           word;
    logic [31:0]           shifted;
    logic [31:0]           load_val;
    logic [3:0]            wr_be;
    logic [31:0]           wr_word;

    // Legality of the request presented this cycle (store wins if both strobes are high).
    always_comb begin
        req_illegal = 1'b0;
        if (MemWrite) begin
            if (funct3 != 3'b000 && funct3 != 3'b001 && funct3 != 3'b010)
                req_illegal = 1'b1;
        end else begin
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                req_illegal = 1'b1;
        end
        // funct3[1:0] encodes size for both loads and stores.
        if (funct3[1:0] == 2'b01 && addr[0])
            req_illegal = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            req_illegal = 1'b1;
    end

    assign access  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign idx     = addr_q[ADDR_WIDTH+1:2];
    assign word    = mem_q[idx];
    assign shifted = word >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = word;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    // Replicate store data across lanes so each byte enable picks the right slice.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = wdata_q;
            end
        endcase
    end

    // RAM is not reset; a write coinciding with a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (access && store_q && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            store_q  <= 1'b0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    fault_q <= 1'b0;
                    if (MemWrite || MemRead) begin
                        addr_q   <= addr[ADDR_WIDTH+1:0];
                        funct3_q <= funct3;
                        wdata_q  <= wdata;
                        store_q  <= MemWrite;
                        if (req_illegal) begin
                            state_q <= DONE;
                            ready_q <= 1'b1;
                            fault_q <= 1'b1;
                            rdata_q <= 32'd0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        rdata_q <= store_q ? 32'd0 : load_val;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign fault = fault_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expected values.
// Latency: checks ready timing against LATENCY; faults expected the cycle after accept.
// Backpressure: requests held until ready, deasserted on the ready cycle.
module tb_data_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        fault;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .fault    (fault),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request at the current (negedge) time and waits for ready.
    // n = number of negedges after driving at which ready was seen (0 = timeout).
    task automatic req(input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt,
                       output int n, output int bsy);
        bit done;
        n = 0; bsy = 0; rd = 32'd0; flt = 1'b0; done = 1'b0;
        MemRead = mr; MemWrite = mw; funct3 = f3; addr = a; wdata = wd;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (ready) begin
                n = i; rd = rdata; flt = fault; done = 1'b1;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd);
        logic [31:0] rd; logic flt; int n; int bsy;
        @(negedge clk);
        req(1'b0, 1'b1, f3, a, wd, rd, flt, n, bsy);
        chk({tag, "_lat"}, n, LAT + 1);
        chk({tag, "_flt"}, {31'd0, flt}, 32'd0);
    endtask

    task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp);
        logic [31:0] rd; logic flt; int n; int bsy;
        @(negedge clk);
        req(1'b1, 1'b0, f3, a, 32'hFFFF_FFFF, rd, flt, n, bsy);
        chk({tag, "_lat"}, n, LAT + 1);
        chk({tag, "_rd"}, rd, exp);
    endtask

    task automatic bad(input string tag, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] rd; logic flt; int n; int bsy;
        @(negedge clk);
        req(mr, mw, f3, a, 32'h1111_1111, rd, flt, n, bsy);
        chk({tag, "_lat"}, n, 1);
        chk({tag, "_flt"}, {31'd0, flt}, 32'd1);
        chk({tag, "_rd"}, rd, 32'd0);
        chk({tag, "_bsy"}, bsy, 0);
        @(negedge clk);
        chk({tag, "_flt_drop"}, {31'd0, fault}, 32'd0);
        chk({tag, "_rdy_drop"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd; logic flt; int n; int bsy;

        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Word store then load, with busy duration check.
        st("sw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        req(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, rd, flt, n, bsy);
        chk("lw10_lat", n, LAT + 1);
        chk("lw10_rd", rd, 32'hDEAD_BEEF);
        chk("lw10_flt", {31'd0, flt}, 32'd0);
        chk("lw10_busy", bsy, LAT);

        ld("lb13",  3'b000, 32'h13, 32'hFFFF_FFDE);
        ld("lbu13", 3'b100, 32'h13, 32'h0000_00DE);
        ld("lh10",  3'b001, 32'h10, 32'hFFFF_BEEF);
        ld("lhu12", 3'b101, 32'h12, 32'h0000_DEAD);
        ld("lbu10", 3'b100, 32'h10, 32'h0000_00EF);

        st("sb11", 3'b000, 32'h11, 32'h0000_00AA);
        ld("lw_sb", 3'b010, 32'h10, 32'hDEAD_AAEF);
        st("sh12", 3'b001, 32'h12, 32'h0000_1234);
        ld("lw_sh", 3'b010, 32'h10, 32'h1234_AAEF);

        // Illegal requests: no RAM change, immediate completion.
        bad("lw_mis", 1'b1, 1'b0, 3'b010, 32'h12);
        bad("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h10);
        bad("sh_odd", 1'b0, 1'b1, 3'b001, 32'h11);
        bad("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h10);
        ld("lw_after_flt", 3'b010, 32'h10, 32'h1234_AAEF);

        // Address aliasing above the RAM size.
        st("sw1004", 3'b010, 32'h1004, 32'h0000_0055);
        ld("lw4", 3'b010, 32'h4, 32'h0000_0055);

        // Both strobes: store wins, rdata reads back 0.
        @(negedge clk);
        req(1'b1, 1'b1, 3'b010, 32'h8, 32'h0000_0077, rd, flt, n, bsy);
        chk("rw_lat", n, LAT + 1);
        chk("rw_rd", rd, 32'd0);
        chk("rw_flt", {31'd0, flt}, 32'd0);
        ld("lw8", 3'b010, 32'h8, 32'h0000_0077);

        // Reset while a store is in WAIT discards the store.
        st("sw20", 3'b010, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        MemWrite = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h1;
        @(negedge clk);
        chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1; MemWrite = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b0;
        req(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, rd, flt, n, bsy);
        chk("post_rst_lat", n, LAT + 1);
        chk("post_rst_rd", rd, 32'hCAFE_F00D);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the single-cycle/multi-cycle RISC-V core. It is the far end of the Controller's MemRead/MemWrite request lines and the ALU's address output.
- Services RV32I loads (lb, lh, lw, lbu, lhu) and stores (sb, sh, sw) against an internal word-organised RAM.
- Completes each access after a programmable wait latency and signals completion with a one-cycle ready pulse.
- Load data feeds the MemtoReg write-back mux into the register file's WriteData.

Parameters:
ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB)
LATENCY, 2, wait cycles from request acceptance to completion; legal range 1..15

Ports:
clk  input  1  core clock, rising-edge
rst  input  1  synchronous, active-high reset
MemRead  input  1  load request from Controller
MemWrite  input  1  store request from Controller
funct3  input  3  instruction[14:12], access size/sign
addr  input  32  byte address (ALUResult)
wdata  input  32  store data (ReadData2)
rdata  output  32  load result, sign/zero-extended
ready  output  1  one-cycle completion pulse
fault  output  1  valid with ready; access rejected
busy  output  1  high while a request is in flight (stall for PC)

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: rdata=0, ready=0, fault=0, busy=0, state=IDLE, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE: sample on every rising edge.
  - If MemWrite=1, accept a store. If MemWrite=1 and MemRead=1 together, the store wins and the read is ignored.
  - Else if MemRead=1, accept a load.
  - On accept, latch addr, funct3, wdata and op.
  - If the request is legal: go to WAIT, load counter with LATENCY-1, busy=1.
  - If the request is illegal: go directly to DONE with fault=1. No RAM access occurs.
- Illegal request conditions:
  - funct3 in {011,110,111} for a load.
  - funct3 not in {000,001,010} for a store.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=00.
- WAIT: decrement the counter each edge. The edge where the counter equals 0 is the access edge:
  - The store writes the RAM.
  - The load result is registered into rdata.
  - Go to DONE.
- DONE: ready=1 for exactly this one cycle; busy drops to 0 in the same cycle; next edge returns to IDLE. fault is valid only while ready=1 and is 0 otherwise.
- Timing: ready is high in the cycle following the LATENCY-th edge after the accepting edge. A faulting request produces ready one edge after acceptance.
- Requester contract: hold the request stable until ready is seen, and deassert it in the cycle after ready. Requests arriving in WAIT or DONE are ignored, with no queueing.
- Addressing: word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias and wrap modulo 4·2^ADDR_WIDTH bytes.
- Loads (byte lane selected by addr[1:0], halfword lane by addr[1]):
  - lb (000): sign-extend the byte.
  - lh (001): sign-extend the halfword.
  - lw (010): full word.
  - lbu (100): zero-extend the byte.
  - lhu (101): zero-extend the halfword.
- Stores:
  - sb writes wdata[7:0] to the addressed lane only.
  - sh writes wdata[15:0] to the addressed halfword.
  - sw writes all 4 bytes.
  - Unaddressed bytes are unchanged. rdata=0 on store completion.
- On fault: rdata=0 and the RAM is unchanged.
- Reset mid-operation: return to IDLE and clear outputs. A store still in WAIT when rst is sampled is discarded (RAM unchanged). A store whose access edge coincides with the rst edge is also discarded.

Test Plan:
- sw addr=0x10 wdata=0xDEADBEEF, LATENCY=2 -> ready 2 edges after accept, fault=0; then lw 0x10 -> rdata=0xDEADBEEF, busy high exactly 2 cycles.
- After the prior store: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; lhu 0x12 -> 0x0000DEAD.
- sb 0x11 wdata=0x000000AA over 0xDEADBEEF -> subsequent lw 0x10 = 0xDEADAAEF. sh 0x12 wdata=0x1234 -> lw = 0x1234AAEF.
- lw addr=0x12 -> ready one edge after accept, fault=1, rdata=0, RAM unchanged. Load funct3=011 -> fault=1.
- Aliasing: sw 0x1004 wdata=0x55 (ADDR_WIDTH=10) -> lw 0x4 returns 0x55. MemRead=MemWrite=1 -> store performed, rdata=0.
- sw 0x20 wdata=0x1 accepted, then rst=1 on the next edge -> outputs reset, lw 0x20 returns its prior contents (not 0x1). A new request accepted on the first edge after rst deasserts.
